// File: rtl/dffram_pkg.sv
// Shared types for the DFFRAM512x32 two-requester arbiter.
// Default geometry, FSM state enum and the RAM request bundle.
package dffram_pkg;

  localparam int AW_DEF    = 9;
  localparam int WSIZE_DEF = 4;
  localparam int DW_DEF    = 8 * WSIZE_DEF;

  typedef enum logic {
    IDLE,
    CLEAR
  } arb_state_e;

  typedef struct packed {
    logic                 en;
    logic [WSIZE_DEF-1:0] we;
    logic [AW_DEF-1:0]    a;
    logic [DW_DEF-1:0]    di;
  } ram_req_t;

endpackage

// File: rtl/dffram_rsp_pipe.sv
// Read-response pipe: RD_LAT-deep {valid,id} shift register.
// Ports: push/push_id in at grant, out_vld/out_id at pipe exit.
module dffram_rsp_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  output logic out_vld,
  output logic out_id
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] id_q, id_d;

  always_comb begin
    vld_d = (vld_q << 1) | RD_LAT'(push);
    id_d  = (id_q << 1) | RD_LAT'(push_id);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_id  = id_q[RD_LAT-1];

endmodule

// File: rtl/dffram_arb2.sv
// Round-robin arbiter + clear sequencer for one DFFRAM512x32 macro.
// Ports: CLK/RSTn, CLR_REQ/BUSY, R0_*/R1_* requesters, RAM_* macro pins.
module dffram_arb2
  import dffram_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int WSIZE      = WSIZE_DEF,
  parameter int RD_LAT     = 1,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CLR_REQ,
  output logic               BUSY,
  input  logic               R0_VALID,
  output logic               R0_READY,
  input  logic [WSIZE-1:0]   R0_WE,
  input  logic [AW-1:0]      R0_A,
  input  logic [8*WSIZE-1:0] R0_DI,
  output logic               R0_RVALID,
  output logic [8*WSIZE-1:0] R0_DO,
  input  logic               R1_VALID,
  output logic               R1_READY,
  input  logic [WSIZE-1:0]   R1_WE,
  input  logic [AW-1:0]      R1_A,
  input  logic [8*WSIZE-1:0] R1_DI,
  output logic               R1_RVALID,
  output logic [8*WSIZE-1:0] R1_DO,
  output logic               RAM_EN,
  output logic [WSIZE-1:0]   RAM_WE,
  output logic [AW-1:0]      RAM_A,
  output logic [8*WSIZE-1:0] RAM_DI,
  input  logic [8*WSIZE-1:0] RAM_DO
);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          prio_q, prio_d;
  ram_req_t      req;
  logic          g0, g1;
  logic          push, push_id;
  logic          rsp_vld, rsp_id;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    prio_d    = prio_q;
    req       = '0;
    R0_READY  = 1'b0;
    R1_READY  = 1'b0;
    push      = 1'b0;
    push_id   = 1'b0;
    g0 = R0_VALID & (~R1_VALID | ~prio_q);
    g1 = R1_VALID & (~R0_VALID | prio_q);
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          g0: begin
            R0_READY = 1'b1;
            req      = '{1'b1, R0_WE, R0_A, R0_DI};
            prio_d   = 1'b1;
            push     = ~|R0_WE;
            push_id  = 1'b0;
          end
          g1: begin
            R1_READY = 1'b1;
            req      = '{1'b1, R1_WE, R1_A, R1_DI};
            prio_d   = 1'b0;
            push     = ~|R1_WE;
            push_id  = 1'b1;
          end
          default: ;
        endcase
        if (CLR_REQ) state_d = CLEAR;
      end
      CLEAR: begin
        req = '{1'b1, '1, clr_cnt_q, '0};
        if (clr_cnt_q == '1) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // Keep the macro and requesters quiet while reset is held,
    // even though the state register already sits in CLEAR.
    if (!RSTn) begin
      req      = '0;
      R0_READY = 1'b0;
      R1_READY = 1'b0;
      push     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= CLR_ON_RST ? CLEAR : IDLE;
      clr_cnt_q <= '0;
      prio_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      prio_q    <= prio_d;
    end
  end

  dffram_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp (
    .clk     (CLK),
    .rst_n   (RSTn),
    .push    (push),
    .push_id (push_id),
    .out_vld (rsp_vld),
    .out_id  (rsp_id)
  );

  assign BUSY      = (state_q == CLEAR);
  assign RAM_EN    = req.en;
  assign RAM_WE    = req.we;
  assign RAM_A     = req.a;
  assign RAM_DI    = req.di;
  assign R0_RVALID = rsp_vld & ~rsp_id;
  assign R1_RVALID = rsp_vld & rsp_id;
  assign R0_DO     = RAM_DO;
  assign R1_DO     = RAM_DO;

endmodule

// File: tb/tb_dffram_arb2.sv
// Randomized bench for dffram_arb2 against a memory/arbitration model.
// Includes a behavioural stand-in for the DFFRAM macro.
module tb_dffram_arb2;

  localparam int AW     = 9;
  localparam int WSIZE  = 4;
  localparam int DEPTH  = 512;
  localparam int RD_LAT = 1;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        CLR_REQ = 1'b0;
  logic        BUSY;
  logic        R0_VALID, R0_READY, R0_RVALID;
  logic        R1_VALID, R1_READY, R1_RVALID;
  logic [3:0]  R0_WE, R1_WE, RAM_WE;
  logic [8:0]  R0_A, R1_A, RAM_A;
  logic [31:0] R0_DI, R1_DI, R0_DO, R1_DO;
  logic        RAM_EN;
  logic [31:0] RAM_DI, RAM_DO;

  always #5 CLK = ~CLK;

  logic        v [2];
  logic [3:0]  we_r [2];
  logic [8:0]  a_r [2];
  logic [31:0] di_r [2];

  assign R0_VALID = v[0];
  assign R0_WE    = we_r[0];
  assign R0_A     = a_r[0];
  assign R0_DI    = di_r[0];
  assign R1_VALID = v[1];
  assign R1_WE    = we_r[1];
  assign R1_A     = a_r[1];
  assign R1_DI    = di_r[1];

  dffram_arb2 #(
    .AW(AW), .WSIZE(WSIZE), .RD_LAT(RD_LAT), .CLR_ON_RST(1'b1)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .CLR_REQ(CLR_REQ), .BUSY(BUSY),
    .R0_VALID(R0_VALID), .R0_READY(R0_READY), .R0_WE(R0_WE),
    .R0_A(R0_A), .R0_DI(R0_DI), .R0_RVALID(R0_RVALID), .R0_DO(R0_DO),
    .R1_VALID(R1_VALID), .R1_READY(R1_READY), .R1_WE(R1_WE),
    .R1_A(R1_A), .R1_DI(R1_DI), .R1_RVALID(R1_RVALID), .R1_DO(R1_DO),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A),
    .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  // Macro stand-in: byte-masked write, registered read (RD_LAT=1).
  logic [31:0] ram [DEPTH];
  logic [31:0] ram_do_q = '0;
  assign RAM_DO = ram_do_q;

  always @(posedge CLK) begin
    if (RAM_EN) begin
      for (int b = 0; b < 4; b++)
        if (RAM_WE[b]) ram[RAM_A][8*b +: 8] <= RAM_DI[8*b +: 8];
      if (RAM_WE == 4'h0) ram_do_q <= ram[RAM_A];
    end
  end

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  int          busy_left;
  int          pref;
  bit          slot_v [8];
  int          slot_id [8];
  logic [31:0] slot_d [8];
  int          cyc;
  int          mode;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic new_req(int id);
    v[id] = 1'b1;
    if (mode == 2) begin
      we_r[id] = 4'h0;
      a_r[id]  = 9'($urandom_range(0, DEPTH - 1));
    end else begin
      we_r[id] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      a_r[id]  = 9'($urandom_range(0, 7)) |
                 ($urandom_range(0, 1) ? 9'h1F8 : 9'h000);
    end
    di_r[id] = $urandom;
  endtask

  task automatic model_reset();
    busy_left = DEPTH;
    pref = 0;
    for (int i = 0; i < 8; i++) slot_v[i] = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  task automatic tick();
    int w;
    int s;
    int ns;
    #1;
    s = cyc % 8;
    w = -1;
    if (busy_left == 0) begin
      if (v[0] && v[1]) w = pref;
      else if (v[0]) w = 0;
      else if (v[1]) w = 1;
    end
    check("busy", BUSY, busy_left > 0);
    check("rdy0", R0_READY, w == 0);
    check("rdy1", R1_READY, w == 1);
    if (busy_left > 0) begin
      check("clr_en", RAM_EN, 1);
      check("clr_we", RAM_WE, 4'hF);
      check("clr_a", RAM_A, DEPTH - busy_left);
      check("clr_di", RAM_DI, 0);
    end else if (w >= 0) begin
      check("en", RAM_EN, 1);
      check("we", RAM_WE, we_r[w]);
      check("a", RAM_A, a_r[w]);
      check("di", RAM_DI, di_r[w]);
    end else begin
      check("idle_en", RAM_EN, 0);
      check("idle_we", RAM_WE, 0);
    end
    check("rv0", R0_RVALID, slot_v[s] && slot_id[s] == 0);
    check("rv1", R1_RVALID, slot_v[s] && slot_id[s] == 1);
    if (slot_v[s]) check("do", slot_id[s] ? R1_DO : R0_DO, slot_d[s]);
    slot_v[s] = 0;
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (w >= 0) begin
        if (we_r[w] == 4'h0) begin
          ns = (cyc + RD_LAT) % 8;
          slot_v[ns]  = 1;
          slot_id[ns] = w;
          slot_d[ns]  = m_mem[a_r[w]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (we_r[w][b]) m_mem[a_r[w]][8*b +: 8] = di_r[w][8*b +: 8];
        end
        pref = 1 - w;
      end
      if (CLR_REQ) begin
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    CLR_REQ = 1'b0;
    if (w >= 0) begin
      v[w] = 1'b0;
      if (mode != 0) new_req(w);
    end
  endtask

  task automatic issue(int id, logic [3:0] we, logic [8:0] a, logic [31:0] d);
    v[id] = 1'b1;
    we_r[id] = we;
    a_r[id] = a;
    di_r[id] = d;
    for (int k = 0; k < 2000 && v[id]; k++) tick();
    check("grant_bound", 32'(v[id]), 0);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    CLR_REQ = 1'b0;
    #1;
    check("rst_busy", BUSY, 1);
    check("rst_rdy0", R0_READY, 0);
    check("rst_rdy1", R1_READY, 0);
    check("rst_en", RAM_EN, 0);
    check("rst_we", RAM_WE, 0);
    check("rst_rv0", R0_RVALID, 0);
    check("rst_rv1", R1_RVALID, 0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    RSTn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    mode = 0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0;
      we_r[i] = '0;
      a_r[i] = '0;
      di_r[i] = '0;
    end
    #2;
    do_reset();

    // Requests held pending through the power-on clear
    v[0] = 1'b1; we_r[0] = 4'h0; a_r[0] = 9'h000;
    v[1] = 1'b1; we_r[1] = 4'h0; a_r[1] = 9'h1FF;
    repeat (DEPTH + 4) tick();
    issue(0, 4'h0, 9'h0FF, 0);
    repeat (2) tick();

    issue(0, 4'hF, 9'h000, 32'hAA0055BB);
    issue(0, 4'h0, 9'h000, 0);
    repeat (2) tick();

    issue(1, 4'hF, 9'h1F2, 32'hF0F055DD);
    issue(1, 4'b0001, 9'h1F2, 32'h00000033);
    issue(1, 4'h0, 9'h1F2, 0);
    issue(0, 4'hF, 9'h1F1, 32'hF0F055DD);
    issue(0, 4'b0100, 9'h1F1, 32'h12345678);
    issue(0, 4'h0, 9'h1F1, 0);
    repeat (2) tick();

    // Contention: R1 goes last so R0 leads the alternation
    issue(1, 4'h0, 9'h1F2, 0);
    mode = 2;
    new_req(0);
    new_req(1);
    repeat (8) tick();
    mode = 0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (3) tick();

    // Clear requested in the same cycle as an R1 read grant
    v[1] = 1'b1; we_r[1] = 4'h0; a_r[1] = 9'h000;
    CLR_REQ = 1'b1;
    tick();
    repeat (10) tick();
    CLR_REQ = 1'b1;
    tick();
    repeat (DEPTH) tick();
    issue(1, 4'h0, 9'h000, 0);
    repeat (2) tick();

    // Random traffic with rare clears
    mode = 1;
    new_req(0);
    new_req(1);
    repeat (800) begin
      if ($urandom_range(0, 299) == 0) CLR_REQ = 1'b1;
      tick();
    end
    mode = 0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    for (int k = 0; k < DEPTH + 4 && busy_left > 0; k++) tick();
    repeat (2) tick();

    // Reset with a read response in flight, then mid-clear
    issue(0, 4'h0, 9'h1F1, 0);
    do_reset();
    repeat (100) tick();
    do_reset();
    repeat (DEPTH + 3) tick();
    issue(0, 4'h0, 9'h1F1, 0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
